// File: rtl/mul_div_unit_pkg.sv
// Shared multiply/divide op codes, FSM states and op-decode helpers.
package mul_div_unit_pkg;

  localparam logic [1:0] MDU_MULT  = 2'd0;
  localparam logic [1:0] MDU_MULTU = 2'd1;
  localparam logic [1:0] MDU_DIV   = 2'd2;
  localparam logic [1:0] MDU_DIVU  = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } mdu_state_e;

  function automatic logic mdu_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic mdu_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/div_core.sv
// Restoring radix-2 divider datapath: one quotient bit per step.
// Operates on magnitudes; sign fix-up is done by the caller.
module div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_nxt,
  output logic [WIDTH-1:0] quo_nxt
);

  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] sub;
  logic             borrow;

  assign shifted = {rem, quo[WIDTH-1]};
  assign borrow  = shifted < {1'b0, dsr};
  // Without borrow the difference is below dsr, so W bits suffice.
  assign sub     = shifted[WIDTH-1:0] - dsr;
  assign rem_nxt = borrow ? shifted[WIDTH-1:0] : sub;
  assign quo_nxt = {quo[WIDTH-2:0], ~borrow};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rem <= '0;
      quo <= '0;
      dsr <= '0;
    end else if (load) begin
      rem <= '0;
      quo <= dividend;
      dsr <= divisor;
    end else if (step) begin
      rem <= rem_nxt;
      quo <= quo_nxt;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit producing HI/LO.
// Define MDU_FAST_MUL_EN for a single-cycle combinational multiply.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div0
);

  localparam int CW = $clog2(WIDTH);

  mdu_state_e       state;
  logic [CW-1:0]    cnt;
  logic             div_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] prod;
  logic             neg_lo;
  logic             neg_hi;
  logic             b_zero;

  logic             sa;
  logic             sb;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             accept;
  logic             last;

  assign sa     = mdu_signed(op) & A[WIDTH-1];
  assign sb     = mdu_signed(op) & B[WIDTH-1];
  assign mag_a  = sa ? -A : A;
  assign mag_b  = sb ? -B : B;
  assign accept = start & ~cancel & (state != CALC);
  assign last   = cnt == CW'(WIDTH - 1);

  logic [WIDTH:0]     msum;
  logic [2*WIDTH-1:0] prod_nxt;
  logic [2*WIDTH-1:0] prod_fin;

  assign msum     = {1'b0, prod[2*WIDTH-1:WIDTH]}
                  + (prod[0] ? {1'b0, mcand} : '0);
  assign prod_nxt = {msum, prod[WIDTH-1:1]};
  assign prod_fin = neg_lo ? -prod_nxt : prod_nxt;

  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;

  div_core #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .resetn   (resetn),
    .load     (accept),
    .step     (state == CALC),
    .dividend (mag_a),
    .divisor  (mag_b),
    .rem_nxt  (rem_nxt),
    .quo_nxt  (quo_nxt)
  );

  // Divide by zero reports the raw captured dividend, not a fixed-up one.
  assign q_fin = b_zero ? '1 : (neg_lo ? -quo_nxt : quo_nxt);
  assign r_fin = b_zero ? a_q : (neg_hi ? -rem_nxt : rem_nxt);

  logic               fast;
  logic [2*WIDTH-1:0] fast_prod;

`ifdef MDU_FAST_MUL_EN
  assign fast      = ~mdu_is_div(op);
  assign fast_prod = op[0]
    ? {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B}
    : $signed({{WIDTH{A[WIDTH-1]}}, A})
      * $signed({{WIDTH{B[WIDTH-1]}}, B});
`else
  assign fast      = 1'b0;
  assign fast_prod = '0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      div0   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      div_q  <= 1'b0;
      a_q    <= '0;
      mcand  <= '0;
      prod   <= '0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      b_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (cancel && state != IDLE) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else if (accept) begin
        div_q  <= mdu_is_div(op);
        a_q    <= A;
        mcand  <= mag_a;
        prod   <= {{WIDTH{1'b0}}, mag_b};
        neg_lo <= sa ^ sb;
        neg_hi <= sa;
        b_zero <= mdu_is_div(op) && B == '0;
        cnt    <= '0;
        if (fast) begin
          state    <= FIN;
          busy     <= 1'b0;
          done     <= 1'b1;
          div0     <= 1'b0;
          {hi, lo} <= fast_prod;
        end else begin
          state <= CALC;
          busy  <= 1'b1;
        end
      end else if (state == CALC) begin
        cnt  <= cnt + CW'(1);
        prod <= prod_nxt;
        if (last) begin
          state <= FIN;
          busy  <= 1'b0;
          done  <= 1'b1;
          div0  <= b_zero;
          if (div_q) begin
            hi <= r_fin;
            lo <= q_fin;
          end else begin
            {hi, lo} <= prod_fin;
          end
        end
      end else begin
        state <= IDLE;
        busy  <= 1'b0;
      end
    end
  end

endmodule
